bus_waitgen: RTL and testbench
==============================

# bus_waitgen

Bus wait-state generator and address decoder on the CPU's external bus. It watches the CPU address/strobe lines (`a`, `n_oe`, `n_we`) and drives the CPU's `n_rdy` input, stretching accesses per memory region. It generates active-low chip selects for ROM, RAM and I/O. I/O accesses can be extended further by the addressed peripheral, with a timeout that raises a sticky bus error.

## Interface
- `ROM_END`, 16'h7FFF, last ROM address; ROM region is `0..ROM_END`.
- `IO_BASE`, 16'hF000, first I/O address; I/O region is `IO_BASE..16'hFFFF`, RAM is everything between ROM and I/O.
- `ROM_WAIT`, 1, wait cycles for ROM accesses (0..15).
- `RAM_WAIT`, 0, wait cycles for RAM accesses (0..15).
- `IO_WAIT`, 2, fixed wait cycles for I/O accesses before the peripheral handshake (0..15).
- `IO_TIMEOUT`, 16, maximum cycles spent waiting on `n_io_rdy` (1..255).
- `clk_in` in 1: clock; all state changes on the rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `a` in 16: CPU address.
- `n_oe` in 1: CPU read strobe, active low.
- `n_we` in 1: CPU write strobe, active low.
- `n_io_rdy` in 1: peripheral ready, active low; sampled only in EXT.
- `err_clr` in 1: synchronous clear of `bus_err`.
- `n_rdy` out 1: to the CPU; low = access may complete, high = stall.
- `n_cs_rom`, `n_cs_ram`, `n_cs_io` out 1 each: chip selects, active low.
- `bus_err` out 1: sticky I/O timeout flag.

## Operation
- `active = ~n_oe | ~n_we`.
- `fresh = active & (~prev_active | a != prev_a)`. `prev_active` and `prev_a` are registered every cycle.
- `W` is the wait count of the region decoded from the current `a`.
- Chip selects are combinational: exactly one is low when `active` is high and it matches the region. All are high when not active.
- States:
  - IDLE: `n_rdy = fresh & (W != 0)`; otherwise 0. On `fresh`:
    - W == 0: go to DONE, or EXT for I/O.
    - W == 1: go to DONE/EXT.
    - W >= 2: load `cnt = W-1`, go to COUNT.
  - COUNT: `n_rdy = 1`; decrement `cnt`. When `cnt == 1`, go to EXT for I/O, otherwise DONE.
  - EXT: `n_rdy = 1`; increment `tmo`, which is cleared on entry.
    - `n_io_rdy == 0` sampled: go to DONE.
    - `tmo == IO_TIMEOUT-1`: go to DONE and set `bus_err`.
  - DONE: `n_rdy = 0` while the same access is held. `~active` returns to IDLE. `fresh` is handled exactly as in IDLE, including combinational `n_rdy` and the transition.
- Total stall for a non-I/O access is exactly W cycles of `n_rdy` high, starting in the cycle `fresh` first appears.
- Abort: `~active` in COUNT or EXT returns to IDLE next edge. No error is raised and `cnt`/`tmo` are discarded.
- `err_clr` clears `bus_err`. If `err_clr` and a timeout occur on the same edge, the set wins.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `tmo` 0, `prev_active` 0, `prev_a` 0, `bus_err` 0.
  - `n_rdy` 0 while `n_rst` is low.
  - Chip selects follow strobes combinationally.
- Reset asserted mid-access forces IDLE immediately. After release, a still-held strobe counts as `fresh` because `prev_active` is 0.
- `n_rdy` depends combinationally on `a`/`n_oe`/`n_we` only in IDLE/DONE, via `fresh`. In COUNT/EXT it is decoded from the state register alone.
- I/O stall is IO_WAIT cycles, plus 1..IO_TIMEOUT cycles in EXT. The extra EXT cycle applies even when `n_io_rdy` is already low.
- A write changing `a` while strobe stays low restarts the sequence for the new region. The old count is discarded.

## Structure
- Package `bus_pkg` holds:
  - region enum (ROM/RAM/IO).
  - state enum (IDLE/COUNT/EXT/DONE).
  - default region bounds and wait constants.
- One sub-module, `bus_addr_decode`: pure combinational `a` → region. It is shared with chip-select generation and wait selection.
- Counters: `cnt` 4 bits, `tmo` 8 bits.

## Test plan
- RAM read at 16'h8000 (RAM_WAIT=0), `n_oe` low 3 cycles -> `n_rdy` never high; `n_cs_ram` low throughout, other selects high.
- ROM read at 16'h0010 (ROM_WAIT=1) -> `n_rdy` high for exactly 1 cycle, then low until `n_oe` rises; `n_cs_rom` low.
- I/O write at 16'hF001, `n_io_rdy` driven low 4 cycles after `n_we` falls -> `n_rdy` high for 2 cycles, stays high in EXT until `n_io_rdy` is sampled low, low the cycle after; `bus_err` 0.
- I/O read at 16'hF000, `n_io_rdy` held high -> `n_rdy` high 2+16 cycles, then low; `bus_err` 1. Pulse `err_clr` -> `bus_err` 0.
- `n_oe` held low while `a` changes 16'h8000 -> 16'h0020 -> new ROM stall of 1 cycle begins in the cycle `a` changes.
- Assert `n_rst` mid-COUNT with ROM_WAIT=4 -> `n_rdy` 0 immediately. Release with `n_oe` still low -> fresh 4-cycle stall.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default constants for the external-bus wait-state generator.
// Region and state encodings live here so the decoder and FSM agree on them.
package bus_pkg;

    typedef enum logic [1:0] {
        REGION_ROM,
        REGION_RAM,
        REGION_IO
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_EXT,
        ST_DONE
    } state_t;

    localparam logic [15:0] DEF_ROM_END    = 16'h7FFF;
    localparam logic [15:0] DEF_IO_BASE    = 16'hF000;
    localparam int          DEF_ROM_WAIT   = 1;
    localparam int          DEF_RAM_WAIT   = 0;
    localparam int          DEF_IO_WAIT    = 2;
    localparam int          DEF_IO_TIMEOUT = 16;

    function automatic logic [3:0] region_wait(region_t r, logic [3:0] rom_w,
                                               logic [3:0] ram_w, logic [3:0] io_w);
        case (r)
            REGION_ROM: return rom_w;
            REGION_IO:  return io_w;
            default:    return ram_w;
        endcase
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Pure combinational address-to-region decoder; drives both chip-select
// generation and wait-count selection in the top level.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter logic [15:0] ROM_END = DEF_ROM_END,
    parameter logic [15:0] IO_BASE = DEF_IO_BASE
) (
    input  logic [15:0] a,
    output region_t     region
);

    always_comb begin
        if (a <= ROM_END) begin
            region = REGION_ROM;
        end else if (a >= IO_BASE) begin
            region = REGION_IO;
        end else begin
            region = REGION_RAM;
        end
    end

endmodule

// File: rtl/bus_waitgen.sv
// Wait-state generator and chip-select decoder for the CPU external bus.
// Stretches each access by a per-region count, then optionally waits on n_io_rdy.
module bus_waitgen
    import bus_pkg::*;
#(
    parameter logic [15:0] ROM_END    = DEF_ROM_END,
    parameter logic [15:0] IO_BASE    = DEF_IO_BASE,
    parameter int          ROM_WAIT   = DEF_ROM_WAIT,
    parameter int          RAM_WAIT   = DEF_RAM_WAIT,
    parameter int          IO_WAIT    = DEF_IO_WAIT,
    parameter int          IO_TIMEOUT = DEF_IO_TIMEOUT
) (
    input  logic        clk_in,
    input  logic        n_rst,
    input  logic [15:0] a,
    input  logic        n_oe,
    input  logic        n_we,
    input  logic        n_io_rdy,
    input  logic        err_clr,
    output logic        n_rdy,
    output logic        n_cs_rom,
    output logic        n_cs_ram,
    output logic        n_cs_io,
    output logic        bus_err
);

    localparam logic [7:0] TMO_LAST = 8'(IO_TIMEOUT - 1);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [7:0]  tmo_reg;
    logic        prev_active_reg;
    logic [15:0] prev_a_reg;
    logic        bus_err_reg;

    region_t     region;
    logic        active;
    logic        fresh;
    logic        is_io;
    logic [3:0]  w;
    logic        tmo_hit;

    bus_addr_decode #(
        .ROM_END (ROM_END),
        .IO_BASE (IO_BASE)
    ) u_decode (
        .a      (a),
        .region (region)
    );

    // A changed address under a held strobe counts as a new access.
    always_comb begin
        active  = ~n_oe | ~n_we;
        fresh   = active & (~prev_active_reg | (a != prev_a_reg));
        is_io   = (region == REGION_IO);
        w       = region_wait(region, 4'(ROM_WAIT), 4'(RAM_WAIT), 4'(IO_WAIT));
        tmo_hit = (state_reg == ST_EXT) & active & ~fresh & n_io_rdy & (tmo_reg == TMO_LAST);
    end

    always_comb begin
        n_rdy = 1'b0;
        if (n_rst) begin
            if (state_reg == ST_COUNT || state_reg == ST_EXT) begin
                n_rdy = 1'b1;
            end else begin
                n_rdy = fresh & (w != 4'd0);
            end
        end
        n_cs_rom = ~(active & (region == REGION_ROM));
        n_cs_ram = ~(active & (region == REGION_RAM));
        n_cs_io  = ~(active & (region == REGION_IO));
        bus_err  = bus_err_reg;
    end

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= 4'd0;
            tmo_reg         <= 8'd0;
            prev_active_reg <= 1'b0;
            prev_a_reg      <= 16'd0;
            bus_err_reg     <= 1'b0;
        end else begin
            prev_active_reg <= active;
            prev_a_reg      <= a;

            if (tmo_hit) begin
                bus_err_reg <= 1'b1;
            end else if (err_clr) begin
                bus_err_reg <= 1'b0;
            end

            if (!active) begin
                state_reg <= ST_IDLE;
            end else if (fresh) begin
                if (w >= 4'd2) begin
                    cnt_reg   <= w - 4'd1;
                    state_reg <= ST_COUNT;
                end else if (is_io) begin
                    tmo_reg   <= 8'd0;
                    state_reg <= ST_EXT;
                end else begin
                    state_reg <= ST_DONE;
                end
            end else begin
                case (state_reg)
                    ST_COUNT: begin
                        cnt_reg <= cnt_reg - 4'd1;
                        if (cnt_reg == 4'd1) begin
                            if (is_io) begin
                                tmo_reg   <= 8'd0;
                                state_reg <= ST_EXT;
                            end else begin
                                state_reg <= ST_DONE;
                            end
                        end
                    end
                    ST_EXT: begin
                        // A ready peripheral takes precedence over a coincident timeout.
                        if (!n_io_rdy || tmo_hit) begin
                            state_reg <= ST_DONE;
                        end else begin
                            tmo_reg <= tmo_reg + 8'd1;
                        end
                    end
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_waitgen.sv
// Bench for bus_waitgen: two instances (ROM_WAIT 1 and 4) share stimulus and
// are checked every cycle against a remaining-stall-count reference model.
module tb_bus_waitgen;

    logic        clk_in;
    logic        n_rst;
    logic [15:0] a;
    logic        n_oe;
    logic        n_we;
    logic        n_io_rdy;
    logic        err_clr;

    logic n_rdy_a, n_cs_rom_a, n_cs_ram_a, n_cs_io_a, bus_err_a;
    logic n_rdy_b, n_cs_rom_b, n_cs_ram_b, n_cs_io_b, bus_err_b;

    int nvec = 0;
    int nerr = 0;

    bus_waitgen dut_a (
        .clk_in   (clk_in),
        .n_rst    (n_rst),
        .a        (a),
        .n_oe     (n_oe),
        .n_we     (n_we),
        .n_io_rdy (n_io_rdy),
        .err_clr  (err_clr),
        .n_rdy    (n_rdy_a),
        .n_cs_rom (n_cs_rom_a),
        .n_cs_ram (n_cs_ram_a),
        .n_cs_io  (n_cs_io_a),
        .bus_err  (bus_err_a)
    );

    bus_waitgen #(.ROM_WAIT(4)) dut_b (
        .clk_in   (clk_in),
        .n_rst    (n_rst),
        .a        (a),
        .n_oe     (n_oe),
        .n_we     (n_we),
        .n_io_rdy (n_io_rdy),
        .err_clr  (err_clr),
        .n_rdy    (n_rdy_b),
        .n_cs_rom (n_cs_rom_b),
        .n_cs_ram (n_cs_ram_b),
        .n_cs_io  (n_cs_io_b),
        .bus_err  (bus_err_b)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: per instance, cycles of fixed stall still owed,
    // whether a peripheral wait follows, and how long it has lasted.
    int          rom_w [2] = '{1, 4};
    int          fix_left [2];
    bit          io_pend [2];
    bit          in_ext [2];
    int          ext_n [2];
    bit          err_m [2];
    bit          pact_m [2];
    logic [15:0] pa_m [2];

    function automatic int wait_of(int m, logic [15:0] addr);
        if (addr <= 16'h7FFF) return rom_w[m];
        if (addr >= 16'hF000) return 2;
        return 0;
    endfunction

    task automatic check(string tag, logic obs, logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s t=%0t a=%h observed=%b expected=%b", tag, $time, a, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            fix_left[m] = 0; io_pend[m] = 0; in_ext[m] = 0; ext_n[m] = 0;
            err_m[m] = 0; pact_m[m] = 0; pa_m[m] = 16'd0;
        end
    endtask

    task automatic tick();
        bit act, fr, io, tmo;
        int w;
        logic [1:0] obs_rdy, obs_rom, obs_ram, obs_io, obs_err;
        bit exp_rdy;
        @(negedge clk_in);
        obs_rdy = {n_rdy_b, n_rdy_a};
        obs_rom = {n_cs_rom_b, n_cs_rom_a};
        obs_ram = {n_cs_ram_b, n_cs_ram_a};
        obs_io  = {n_cs_io_b, n_cs_io_a};
        obs_err = {bus_err_b, bus_err_a};
        act = !n_oe || !n_we;
        for (int m = 0; m < 2; m++) begin
            fr = act && (!pact_m[m] || a != pa_m[m]);
            w  = wait_of(m, a);
            exp_rdy = n_rst && ((fix_left[m] > 0) || in_ext[m] || (fr && w != 0));
            check(m == 0 ? "n_rdy0" : "n_rdy1", obs_rdy[m], exp_rdy);
            check(m == 0 ? "cs_rom0" : "cs_rom1", obs_rom[m], !(act && a <= 16'h7FFF));
            check(m == 0 ? "cs_ram0" : "cs_ram1", obs_ram[m], !(act && a > 16'h7FFF && a < 16'hF000));
            check(m == 0 ? "cs_io0" : "cs_io1", obs_io[m], !(act && a >= 16'hF000));
            check(m == 0 ? "bus_err0" : "bus_err1", obs_err[m], err_m[m]);
        end
        @(posedge clk_in);
        if (!n_rst) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                fr  = act && (!pact_m[m] || a != pa_m[m]);
                w   = wait_of(m, a);
                io  = (a >= 16'hF000);
                tmo = 0;
                if (!act) begin
                    fix_left[m] = 0; in_ext[m] = 0;
                end else if (fr) begin
                    io_pend[m]  = io;
                    fix_left[m] = (w >= 1) ? w - 1 : 0;
                    in_ext[m]   = io && (w <= 1);
                    ext_n[m]    = 0;
                end else if (fix_left[m] > 0) begin
                    fix_left[m]--;
                    if (fix_left[m] == 0 && io_pend[m]) begin
                        in_ext[m] = 1; ext_n[m] = 0;
                    end
                end else if (in_ext[m]) begin
                    if (!n_io_rdy) in_ext[m] = 0;
                    else if (ext_n[m] == 15) begin in_ext[m] = 0; tmo = 1; end
                    else ext_n[m]++;
                end
                if (tmo) err_m[m] = 1;
                else if (err_clr) err_m[m] = 0;
                pact_m[m] = act;
                pa_m[m]   = a;
            end
        end
        #1;
    endtask

    task automatic apply(logic rst, logic [15:0] addr, logic oe, logic we,
                         logic iordy, logic clr, int n);
        n_rst = rst; a = addr; n_oe = oe; n_we = we; n_io_rdy = iordy; err_clr = clr;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [15:0] addr;
        logic [15:0] edges [6];
        int len, kind;
        bit use_we;
        edges = '{16'h0000, 16'h7FFF, 16'h8000, 16'hEFFF, 16'hF000, 16'hFFFF};
        model_reset();
        n_rst = 0; a = 16'h0000; n_oe = 1; n_we = 1; n_io_rdy = 1; err_clr = 0;
        #1;
        apply(0, 16'h0000, 1, 1, 1, 0, 2);
        apply(1, 16'h0000, 1, 1, 1, 0, 2);
        // RAM read, zero waits
        apply(1, 16'h8000, 0, 1, 1, 0, 3);
        apply(1, 16'h8000, 1, 1, 1, 0, 1);
        // ROM read
        apply(1, 16'h0010, 0, 1, 1, 0, 6);
        apply(1, 16'h0010, 1, 1, 1, 0, 1);
        // I/O write, peripheral ready after 4 cycles
        apply(1, 16'hF001, 1, 0, 1, 0, 4);
        apply(1, 16'hF001, 1, 0, 0, 0, 2);
        apply(1, 16'hF001, 1, 1, 1, 0, 1);
        // I/O read timing out, then clear the error
        apply(1, 16'hF000, 0, 1, 1, 0, 22);
        apply(1, 16'hF000, 1, 1, 1, 0, 2);
        apply(1, 16'hF000, 1, 1, 1, 1, 1);
        apply(1, 16'hF000, 1, 1, 1, 0, 2);
        // Address change under a held strobe
        apply(1, 16'h8000, 0, 1, 1, 0, 2);
        apply(1, 16'h0020, 0, 1, 1, 0, 6);
        apply(1, 16'h0020, 1, 1, 1, 0, 1);
        // Reset in the middle of a ROM stall, released with strobe held
        apply(1, 16'h0010, 0, 1, 1, 0, 2);
        apply(0, 16'h0010, 0, 1, 1, 0, 1);
        apply(1, 16'h0010, 0, 1, 1, 0, 6);
        apply(1, 16'h0010, 1, 1, 1, 0, 1);

        for (int k = 0; k < 120; k++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: addr = 16'($urandom_range(0, 16'h7FFF));
                1: addr = 16'($urandom_range(16'h8000, 16'hEFFF));
                2: addr = 16'($urandom_range(16'hF000, 16'hFFFF));
                default: addr = edges[$urandom_range(0, 5)];
            endcase
            use_we = ($urandom_range(0, 1) == 1);
            len    = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 11) == 0) addr = edges[$urandom_range(0, 5)];
                apply(($urandom_range(0, 99) != 0), addr,
                      use_we ? 1'b1 : 1'b0, use_we ? 1'b0 : 1'b1,
                      ($urandom_range(0, 6) != 0), ($urandom_range(0, 15) == 0), 1);
            end
            if ($urandom_range(0, 2) != 0)
                apply(1, addr, 1, 1, 1, ($urandom_range(0, 7) == 0), $urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
